// File: rtl/kr_clock_sequencer.sv
// Lock-qualified reset and clock-enable sequencer for the 72 MHz system clock domain.
// Holds the core in reset until PLL lock has been stable for RST_HOLD cycles, then runs the enable dividers.
module kr_clock_sequencer #(
    parameter int CPU_DIV  = 12,
    parameter int MCU_DIV  = 18,
    parameter int SND_DIV  = 24,
    parameter int PIX_DIV  = 12,
    parameter int RST_HOLD = 1024
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pll_locked,
    input  logic pause,
    output logic core_reset,
    output logic running,
    output logic ce_cpu,
    output logic ce_mcu,
    output logic ce_snd,
    output logic ce_pix,
    output logic ce_pix_n
);

    localparam int CPU_W  = $clog2(CPU_DIV);
    localparam int MCU_W  = $clog2(MCU_DIV);
    localparam int SND_W  = $clog2(SND_DIV);
    localparam int PIX_W  = $clog2(PIX_DIV);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);
    localparam logic [MCU_W-1:0]  MCU_LAST  = MCU_W'(MCU_DIV - 1);
    localparam logic [SND_W-1:0]  SND_LAST  = SND_W'(SND_DIV - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
    localparam logic [PIX_W-1:0]  PIX_HALF  = PIX_W'(PIX_DIV / 2 - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_lk1;
    logic                r_lk2;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [CPU_W-1:0]    r_cpu_cnt;
    logic [MCU_W-1:0]    r_mcu_cnt;
    logic [SND_W-1:0]    r_snd_cnt;
    logic [PIX_W-1:0]    r_pix_cnt;
    logic                w_active;
    logic                w_gate;

    // pll_locked is asynchronous to clk_sys; only the second flop is trusted.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_lk1 <= 1'b0;
            r_lk2 <= 1'b0;
        end else begin
            r_lk1 <= pll_locked;
            r_lk2 <= r_lk1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_LOCK: if (r_lk2) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (!r_lk2) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:       if (!r_lk2) w_state_nxt = S_WAIT_LOCK;
            default:     w_state_nxt = S_WAIT_LOCK;
        endcase
    end

    assign w_active = (r_state != S_WAIT_LOCK);

    // Counters sit at zero throughout WAIT_LOCK so every HOLD entry starts from the same phase.
    always_ff @(posedge clk_sys) begin
        if (reset || !w_active) begin
            r_hold_cnt <= '0;
            r_cpu_cnt  <= '0;
            r_mcu_cnt  <= '0;
            r_snd_cnt  <= '0;
            r_pix_cnt  <= '0;
        end else begin
            if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            r_cpu_cnt <= (r_cpu_cnt == CPU_LAST) ? '0 : r_cpu_cnt + CPU_W'(1);
            r_mcu_cnt <= (r_mcu_cnt == MCU_LAST) ? '0 : r_mcu_cnt + MCU_W'(1);
            r_snd_cnt <= (r_snd_cnt == SND_LAST) ? '0 : r_snd_cnt + SND_W'(1);
            r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + PIX_W'(1);
        end
    end

    // Pause only masks the processor/sound enables; counters keep their phase.
    assign w_gate = w_active && !((r_state == S_RUN) && pause);

    assign ce_cpu     = w_gate   && (r_cpu_cnt == CPU_LAST);
    assign ce_mcu     = w_gate   && (r_mcu_cnt == MCU_LAST);
    assign ce_snd     = w_gate   && (r_snd_cnt == SND_LAST);
    assign ce_pix     = w_active && (r_pix_cnt == PIX_LAST);
    assign ce_pix_n   = w_active && (r_pix_cnt == PIX_HALF);
    assign core_reset = (r_state != S_RUN);
    assign running    = (r_state == S_RUN);

endmodule

// File: tb/tb_kr_clock_sequencer.sv
// Directed bench for kr_clock_sequencer with RST_HOLD=16: startup table, rates, pause, lock loss, reset and glitch.
module tb_kr_clock_sequencer;

    logic clk_sys = 1'b0;
    logic reset;
    logic pll_locked;
    logic pause;
    logic core_reset;
    logic running;
    logic ce_cpu;
    logic ce_mcu;
    logic ce_snd;
    logic ce_pix;
    logic ce_pix_n;

    int n_checks = 0;
    int n_fail   = 0;
    int tcyc     = 0;

    kr_clock_sequencer #(
        .CPU_DIV (12),
        .MCU_DIV (18),
        .SND_DIV (24),
        .PIX_DIV (12),
        .RST_HOLD(16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .pll_locked(pll_locked),
        .pause     (pause),
        .core_reset(core_reset),
        .running   (running),
        .ce_cpu    (ce_cpu),
        .ce_mcu    (ce_mcu),
        .ce_snd    (ce_snd),
        .ce_pix    (ce_pix),
        .ce_pix_n  (ce_pix_n)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       rst;
        logic       lk;
        logic       pse;
        logic       chk;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[26];

    // Output bundle order: {core_reset, running, ce_cpu, ce_mcu, ce_snd, ce_pix, ce_pix_n}
    function automatic logic [6:0] outs();
        return {core_reset, running, ce_cpu, ce_mcu, ce_snd, ce_pix, ce_pix_n};
    endfunction

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp,
                       input logic [6:0] mask);
        n_checks++;
        if ((got & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%b expected=%b mask=%b", name, tcyc, got, exp, mask);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, tcyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        tcyc++;
    endtask

    // Called at the start of the first HOLD cycle; walks h=0..16.
    task automatic hold_seq(input string name);
        logic [6:0] e;
        for (int h = 0; h <= 16; h++) begin
            e = {(h < 16), (h == 16), (h == 11), 1'b0, 1'b0, (h == 11), (h == 5)};
            #1;
            chk(name, outs(), e, 7'h7F);
            tick();
        end
    endtask

    task automatic find_cpu(output logic found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (ce_cpu === 1'b1) found = 1'b1;
            else tick();
        end
        chk_int("find_cpu_timeout", int'(found), 1);
    endtask

    initial begin
        int n_cpu, n_mcu, n_snd, n_pix, n_pixn;
        int last_pix, last_pixn;
        logic found;
        logic [6:0] e;
        logic [6:0] m;
        logic cpu_e;

        reset      = 1'b1;
        pll_locked = 1'b1;
        pause      = 1'b0;

        // Startup: reset for cycles 0..3, HOLD from cycle 7 (h = cycle-7).
        for (int i = 0; i < 26; i++) begin
            tbl[i].rst = (i < 4);
            tbl[i].lk  = 1'b1;
            tbl[i].pse = 1'b0;
            tbl[i].chk = (i >= 1);
            tbl[i].exp = 7'b1000000;
        end
        tbl[12].exp = 7'b1000001;
        tbl[18].exp = 7'b1010010;
        tbl[23].exp = 7'b0100000;
        tbl[24].exp = 7'b0101001;
        tbl[25].exp = 7'b0100000;

        for (int i = 0; i < 26; i++) begin
            reset      = tbl[i].rst;
            pll_locked = tbl[i].lk;
            pause      = tbl[i].pse;
            #1;
            if (tbl[i].chk) chk("startup", outs(), tbl[i].exp, 7'h7F);
            tick();
        end

        // Rate check over 7200 RUN cycles.
        n_cpu = 0; n_mcu = 0; n_snd = 0; n_pix = 0; n_pixn = 0;
        last_pix = -1; last_pixn = -1;
        for (int i = 0; i < 7200; i++) begin
            #1;
            if (ce_cpu) n_cpu++;
            if (ce_mcu) n_mcu++;
            if (ce_snd) n_snd++;
            if (ce_pix) begin
                n_pix++;
                chk("pix_overlap", {6'd0, ce_pix_n}, 7'd0, 7'h7F);
                if (last_pixn >= 0) chk_int("pixn_to_pix_gap", tcyc - last_pixn, 6);
                last_pix = tcyc;
            end
            if (ce_pix_n) begin
                n_pixn++;
                if (last_pix >= 0) chk_int("pix_to_pixn_gap", tcyc - last_pix, 6);
                last_pixn = tcyc;
            end
            tick();
        end
        chk_int("rate_cpu", n_cpu, 600);
        chk_int("rate_mcu", n_mcu, 400);
        chk_int("rate_snd", n_snd, 300);
        chk_int("rate_pix", n_pix, 600);
        chk_int("rate_pixn", n_pixn, 600);

        // Pause for 100 cycles starting on a cpu wrap cycle (k=12).
        find_cpu(found);
        for (int k = 1; k <= 140; k++) begin
            tick();
            pause = (k >= 12 && k < 112);
            #1;
            cpu_e = ((k % 12) == 0) && !pause;
            e = {1'b0, 1'b1, cpu_e, 1'b0, 1'b0, ((k % 12) == 0), ((k % 12) == 6)};
            m = pause ? 7'h7F : 7'b1110011;
            chk(pause ? "pause_hold" : "pause_grid", outs(), e, m);
        end
        pause = 1'b0;
        tick();

        // Lock loss in RUN, then relock with a full hold sequence.
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lockloss_still_run", outs(), 7'b0100000, 7'b1100000);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lockloss_wait", outs(), 7'b1000000, 7'h7F);
            tick();
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("relock_wait", outs(), 7'b1000000, 7'h7F);
            tick();
        end
        hold_seq("relock_hold");

        // One-cycle glitch low on pll_locked while running.
        pll_locked = 1'b0;
        #1;
        chk("glitch_run0", outs(), 7'b0100000, 7'b1100000);
        tick();
        pll_locked = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("glitch_run", outs(), 7'b0100000, 7'b1100000);
            tick();
        end
        #1;
        chk("glitch_wait", outs(), 7'b1000000, 7'h7F);
        tick();
        hold_seq("glitch_hold");

        // Another glitch to re-enter HOLD, then reset at h=5.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_pre_wait", outs(), 7'b1000000, 7'h7F);
        tick();
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("rst_pre_hold", outs(), 7'b1000000, 7'h7F);
            tick();
        end
        reset = 1'b1;
        #1;
        chk("rst_at_h5", outs(), 7'b1000001, 7'h7F);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_wait", outs(), 7'b1000000, 7'h7F);
            tick();
        end
        hold_seq("rst_hold");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kr_clock_sequencer.md
# kr_clock_sequencer

Clock-enable and reset sequencer that sits directly downstream of the 50→72 MHz system PLL. It consumes the PLL's 72 MHz output as `clk_sys` and its `locked` flag. It holds the game core in reset until the PLL is stably locked plus a fixed hold time, then produces the single-cycle clock enables for the main CPU, MCU, sound chip and pixel pipeline. Every other block in the core runs on `clk_sys` gated by these enables.

## Interface

Parameters:
- `CPU_DIV`, 12, main Z80 enable divisor (72/12 = 6 MHz); must be ≥2.
- `MCU_DIV`, 18, MCU enable divisor (4 MHz); must be ≥2.
- `SND_DIV`, 24, YM2203 enable divisor (3 MHz); must be ≥2.
- `PIX_DIV`, 12, pixel enable divisor (6 MHz); must be even and ≥4.
- `RST_HOLD`, 1024, number of HOLD-state cycles before `core_reset` is released; must be ≥1.

Ports:
- `clk_sys`, in, 1, 72 MHz system clock from the PLL. This is the only clock.
- `reset`, in, 1, synchronous, active-high.
- `pll_locked`, in, 1, PLL lock flag; asynchronous to `clk_sys`.
- `pause`, in, 1, gates CPU, MCU and sound enables while in RUN.
- `core_reset`, out, 1, reset to the game core.
- `running`, out, 1, high in RUN state.
- `ce_cpu`, `ce_mcu`, `ce_snd`, out, 1 each, single-cycle clock enables.
- `ce_pix`, out, 1, single-cycle pixel enable.
- `ce_pix_n`, out, 1, pixel enable in opposite phase.

## Operation

- **Synchronizer:** `pll_locked` passes through a 2-flop synchronizer (`lk1`→`lk2`). Both flops are cleared by `reset`. The FSM uses only `lk2`.
- **WAIT_LOCK (reset state):**
  - Hold counter and all divider counters are forced to 0.
  - `core_reset`=1, `running`=0, all enables 0.
  - Go to HOLD when `lk2`=1.
- **HOLD:**
  - Divider counters run, and all enables pulse, so the core sees clocks while in reset.
  - `core_reset`=1.
  - The hold counter increments each cycle. After the cycle in which it equals `RST_HOLD`-1, go to RUN.
  - If `lk2`=0, go to WAIT_LOCK.
- **RUN:**
  - `core_reset`=0, `running`=1.
  - If `lk2`=0, go to WAIT_LOCK.
- **`reset`=1 (any state):** WAIT_LOCK on the next cycle; all counters cleared.
- **Dividers:** one counter per divisor, each counting 0..DIV-1 and wrapping to 0.
  - All counters are 0 in the first HOLD cycle, so phases are fixed relative to lock.
  - Counter width is clog2(DIV).
  - `ce_x` is high exactly in cycles where its counter = DIV-1 and state ≠ WAIT_LOCK. It is decoded from registered state only, so it is glitch-free.
  - `ce_pix_n` is high where the pix counter = PIX_DIV/2-1, so it never coincides with `ce_pix`.
- **Pause:**
  - In RUN with `pause`=1, `ce_cpu`, `ce_mcu` and `ce_snd` are forced to 0.
  - Counters keep running, so the phase is preserved on resume.
  - `ce_pix` and `ce_pix_n` are unaffected.
  - Pause has no effect in HOLD.

## Timing

- **Reset values:** `core_reset`=1; `running`, `ce_cpu`, `ce_mcu`, `ce_snd`, `ce_pix`, `ce_pix_n` all 0.
- **Lock to HOLD:** `pll_locked` rising in cycle n gives `lk2`=1 in cycle n+2 and HOLD from cycle n+3.
- **HOLD cycle numbering:** index the first HOLD cycle as h=0.
  - `ce_cpu` fires at h=11, 23, …
  - `ce_pix_n` fires at h=5, 17, …
  - `ce_mcu` fires at h=17, 35, …
  - `ce_snd` fires at h=23, 47, …
- **Release:** RUN starts at h=`RST_HOLD`; `core_reset` falls in that cycle.
- **Lock loss:** `pll_locked` falling in cycle n gives WAIT_LOCK in cycle n+3. From cycle n+3, all enables are 0 and `core_reset`=1.
- **Simultaneous events:**
  - `reset` takes priority over everything.
  - Lock loss in the same cycle as hold completion goes to WAIT_LOCK.
  - Pause asserted in the same cycle as a wrap suppresses that pulse.
- **Relock:** always restarts a full `RST_HOLD` sequence from h=0.

## Test plan

1. **Startup:** `RST_HOLD`=16, `pll_locked`=1 throughout, `reset` high for 4 cycles, then low → HOLD begins 3 cycles after `reset` falls. Require `ce_cpu` at h=11, `ce_pix_n` at h=5, `core_reset` falling at h=16 and `running`=1 from h=16.
2. **Rate check:** 7200 cycles in RUN → 600 `ce_cpu`, 400 `ce_mcu`, 300 `ce_snd`, 600 `ce_pix` and 600 `ce_pix_n`. Require `ce_pix` and `ce_pix_n` to never be high in the same cycle and to be always 6 cycles apart.
3. **Lock loss in RUN:** drop `pll_locked` at cycle n → `core_reset`=1 and all enables 0 from n+3. Reassert it → a full 16-cycle HOLD, with `ce_cpu` again first at h=11.
4. **Pause:** `pause`=1 for 100 cycles in RUN → `ce_cpu`, `ce_mcu` and `ce_snd` stay 0 while `ce_pix` keeps pulsing every 12 cycles. After release, `ce_cpu` resumes on its original 12-cycle grid.
5. **Reset mid-HOLD:** assert `reset` at h=5 → WAIT_LOCK next cycle with all enables 0. After release, the hold counter restarts and `core_reset` falls 16 cycles after HOLD re-entry.
6. **Glitch:** a 1-cycle low pulse on `pll_locked` in RUN, sampled by `lk1` → WAIT_LOCK, followed by a full HOLD sequence.
